// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: response owner/type encodings and the
// byte-to-word address shift used on the RAM write path.
package sp_ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        RSP_READ  = 1'b0,
        RSP_WRITE = 1'b1
    } rsp_e;

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/sp_ram_arb_pick.sv
// Two-way combinational grant pick. The caller supplies which port is preferred on
// contention, so the same logic serves fixed-priority and round-robin policies.
module sp_ram_arb_pick
    import sp_ram_arb_pkg::*;
(
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    input  logic if_first,
    output logic if_gnt,
    output logic d_gnt,
    output logic contended
);

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        contended = 1'b0;
        if (en) begin
            if (if_req && d_req) begin
                contended = 1'b1;
                if (if_first) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

endmodule

// File: rtl/sp_ram_port_arbiter.sv
// Shares one single-port RAM between a fetch port and a load/store port, one grant per cycle.
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority instead of d-first with MAX_WAIT aging.
module sp_ram_port_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_wack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_re,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(3);

    logic   if_first;
    logic   contended;
    owner_e resp_owner;
    rsp_e   resp_type;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

    sp_ram_arb_pick u_pick (
        .en        (!rst),
        .if_req    (if_req),
        .d_req     (d_req),
        .if_first  (if_first),
        .if_gnt    (if_gnt),
        .d_gnt     (d_gnt),
        .contended (contended)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer moves only on contention so the first contention after reset always favours d_*.
    logic rr_if_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_if_first <= 1'b0;
        end else if (contended) begin
            rr_if_first <= d_gnt;
        end
    end

    assign if_first = rr_if_first;
`else
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    logic [WCW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (if_gnt) begin
            wait_cnt <= '0;
        end else if (if_req && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign if_first = (wait_cnt == WAIT_LIMIT);

    logic unused_contended;
    assign unused_contended = contended;
`endif

    // Reads see byte addresses; writes see the word index.
    always_comb begin
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        if (if_gnt) begin
            ram_re      = 1'b1;
            ram_address = if_addr & ~ALIGN_MASK;
        end else if (d_gnt) begin
            if (d_we) begin
                ram_we      = 1'b1;
                ram_address = d_addr >> WORD_SHIFT;
                ram_data_in = d_wdata;
            end else begin
                ram_re      = 1'b1;
                ram_address = d_addr & ~ALIGN_MASK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner <= OWN_NONE;
            resp_type  <= RSP_READ;
        end else if (if_gnt) begin
            resp_owner <= OWN_IF;
            resp_type  <= RSP_READ;
        end else if (d_gnt) begin
            resp_owner <= OWN_D;
            resp_type  <= d_we ? RSP_WRITE : RSP_READ;
        end else begin
            resp_owner <= OWN_NONE;
            resp_type  <= RSP_READ;
        end
    end

    assign if_rvalid = (resp_owner == OWN_IF);
    assign d_rvalid  = (resp_owner == OWN_D) && (resp_type == RSP_READ);
    assign d_wack    = (resp_owner == OWN_D) && (resp_type == RSP_WRITE);

    // RAM data is only live during the response cycle, so keep a copy for the hold period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= ram_data_out;
            end
            if (d_rvalid) begin
                d_rdata_q <= ram_data_out;
            end
        end
    end

    assign if_rdata = if_rvalid ? ram_data_out : if_rdata_q;
    assign d_rdata  = d_rvalid  ? ram_data_out : d_rdata_q;

endmodule

// File: tb/tb_sp_ram_port_arbiter.sv
// Directed bench for sp_ram_port_arbiter with a behavioural single-port RAM
// (read on posedge with byte address, write on negedge with word index).
module tb_sp_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_wack;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_data_out;

    logic [31:0] mem [64];
    logic        mem_init;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sp_ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_wack       (d_wack),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_re       (ram_re),
        .ram_we       (ram_we),
        .ram_data_out (ram_data_out)
    );

    always @(posedge clk) begin
        if (ram_re) ram_data_out <= mem[ram_address[7:2]];
    end

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (ram_we) begin
            mem[ram_address[5:0]] <= ram_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h1111_2222;

        // reset: nothing granted, all outputs zero even with requests pending
        tick;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_ram_din", ram_data_in, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_wack", d_wack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        #1;
        mem_init = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        // 1: single fetch of 0x8
        tick;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h8;
        #3;
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_d_gnt", d_gnt, 0);
        chk("t1_ram_re", ram_re, 1);
        chk("t1_ram_we", ram_we, 0);
        chk("t1_ram_addr", ram_address, 32'h8);
        tick;
        if_req = 1'b0;
        #3;
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 32'hA000_0002);
        chk("t1_d_rvalid", d_rvalid, 0);
        tick;
        if_req = 1'b1; if_addr = 32'hB;
        #3;
        chk("t1_hold_rvalid", if_rvalid, 0);
        chk("t1_hold_rdata", if_rdata, 32'hA000_0002);
        chk("t1_unaligned_addr", ram_address, 32'h8);

        // 2: store 0xC then load it back
        tick;
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hDEAD_BEEF;
        #3;
        chk("t2_st_d_gnt", d_gnt, 1);
        chk("t2_st_if_gnt", if_gnt, 0);
        chk("t2_st_ram_we", ram_we, 1);
        chk("t2_st_ram_re", ram_re, 0);
        chk("t2_st_ram_addr", ram_address, 32'h3);
        chk("t2_st_ram_din", ram_data_in, 32'hDEAD_BEEF);
        tick;
        d_we = 1'b0;
        #3;
        chk("t2_wack", d_wack, 1);
        chk("t2_wack_no_rvalid", d_rvalid, 0);
        chk("t2_ld_ram_re", ram_re, 1);
        chk("t2_ld_ram_addr", ram_address, 32'hC);
        chk("t2_ld_ram_din", ram_data_in, 0);
        tick;
        d_req = 1'b0;
        #3;
        chk("t2_ld_rvalid", d_rvalid, 1);
        chk("t2_ld_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t2_ld_no_wack", d_wack, 0);

        // 3/4: both ports request continuously for 8 cycles
`ifdef ARB_ROUND_ROBIN_EN
        pat = 8'h55;
`else
        pat = 8'hEF;
`endif
        tick;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        for (int i = 0; i < 8; i++) begin
            #3;
            chk($sformatf("t3_d_gnt_%0d", i), d_gnt, pat[i]);
            chk($sformatf("t3_if_gnt_%0d", i), if_gnt, !pat[i]);
            chk($sformatf("t3_one_gnt_%0d", i), if_gnt & d_gnt, 0);
            if (i > 0) begin
                chk($sformatf("t3_d_rvalid_%0d", i), d_rvalid, pat[i-1]);
                chk($sformatf("t3_if_rvalid_%0d", i), if_rvalid, !pat[i-1]);
                if (pat[i-1]) chk($sformatf("t3_d_rdata_%0d", i), d_rdata, 32'hA000_0005);
                else          chk($sformatf("t3_if_rdata_%0d", i), if_rdata, 32'hA000_0004);
            end
            tick;
        end
        if_req = 1'b0; d_req = 1'b0;
        #3;
        chk("t3_last_d_rvalid", d_rvalid, pat[7]);
        chk("t3_last_if_rvalid", if_rvalid, !pat[7]);

        // 5: back-to-back fetches 0x0, 0x4, 0x8
        tick;
        if_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if_addr = 32'(j * 4);
            #3;
            chk($sformatf("t5_gnt_%0d", j), if_gnt, 1);
            chk($sformatf("t5_addr_%0d", j), ram_address, 32'(j * 4));
            if (j > 0) begin
                chk($sformatf("t5_rvalid_%0d", j), if_rvalid, 1);
                chk($sformatf("t5_rdata_%0d", j), if_rdata, 32'hA000_0000 + 32'(j - 1));
            end
            tick;
        end
        if_req = 1'b0;
        #3;
        chk("t5_rvalid_2", if_rvalid, 1);
        chk("t5_rdata_2", if_rdata, 32'hA000_0002);
        tick;
        chk("t5_rvalid_end", if_rvalid, 0);

        // 6: reset lands the cycle after a load grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        #3;
        chk("t6_d_gnt", d_gnt, 1);
        tick;
        rst = 1'b1;
        #1;
        chk("t6_rst_d_rvalid", d_rvalid, 0);
        chk("t6_rst_d_gnt", d_gnt, 0);
        chk("t6_rst_ram_re", ram_re, 0);
        chk("t6_rst_ram_addr", ram_address, 0);
        chk("t6_rst_d_rdata", d_rdata, 0);
        chk("t6_rst_if_rdata", if_rdata, 0);
        tick;
        rst = 1'b0; d_req = 1'b0;
        #3;
        chk("t6_post_d_rvalid", d_rvalid, 0);
        tick;
        chk("t6_post2_d_rvalid", d_rvalid, 0);
        chk("t6_post2_d_wack", d_wack, 0);
        chk("t6_post2_if_rvalid", if_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
